// File: rtl/button_conditioner.sv
// Per-button synchronizer and debounce FSM for the three player buttons.
// Produces a clean level plus one-cycle press, release and long-hold pulses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red_button,
    input  logic       blue_button,
    input  logic       yellow_button,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic [2:0] btn_release,
    output logic [2:0] btn_hold,
    output logic       any_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HCNT_FIRE = HW'(HOLD_CYCLES - 2);

    // Bit 1 of the state is the debounced level: set in HELD and RELEASE_WAIT.
    localparam logic [1:0] ST_IDLE         = 2'b00;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;
    localparam logic [1:0] ST_HELD         = 2'b10;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'b11;

    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_press_nxt;
    logic       r_any_press;

    assign w_raw = {yellow_button, blue_button, red_button};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic [1:0]    r_state;
        logic [1:0]    w_state_nxt;
        logic [DW-1:0] r_dcnt;
        logic [DW-1:0] w_dcnt_nxt;
        logic [HW-1:0] r_hcnt;
        logic [HW-1:0] w_hcnt_nxt;
        logic          r_press;
        logic          r_release;
        logic          r_hold;
        logic          w_press_b;
        logic          w_release_b;
        logic          w_hold_b;
        logic          w_s;

        assign w_s = r_sync2[g];

        always_comb begin
            // NOTE: every output of this block gets a default first, so no latch is inferred.
            w_state_nxt = r_state;
            w_dcnt_nxt  = r_dcnt;
            w_hcnt_nxt  = r_hcnt;
            w_press_b   = 1'b0;
            w_release_b = 1'b0;
            w_hold_b    = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_dcnt_nxt  = DCNT_ONE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_s) begin
                        w_state_nxt = ST_IDLE;
                        w_dcnt_nxt  = '0;
                    end else if (r_dcnt == DCNT_LAST) begin
                        w_state_nxt = ST_HELD;
                        w_hcnt_nxt  = '0;
                        w_press_b   = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt + DW'(1);
                    end
                end
                ST_HELD: begin
                    if (!w_s) begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_dcnt_nxt  = DCNT_ONE;
                    end else if (r_hcnt != HCNT_MAX) begin
                        // Saturation guarantees hcnt passes HOLD_CYCLES-1 once per press.
                        w_hcnt_nxt = r_hcnt + HW'(1);
                        w_hold_b   = (r_hcnt == HCNT_FIRE);
                    end
                end
                default: begin
                    if (w_s) begin
                        w_state_nxt = ST_HELD;
                    end else if (r_dcnt == DCNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_release_b = 1'b1;
                    end else begin
                        w_dcnt_nxt = r_dcnt + DW'(1);
                    end
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= ST_IDLE;
                r_dcnt    <= '0;
                r_hcnt    <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_hold    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_dcnt    <= w_dcnt_nxt;
                r_hcnt    <= w_hcnt_nxt;
                r_press   <= w_press_b;
                r_release <= w_release_b;
                r_hold    <= w_hold_b;
            end
        end

        assign w_press_nxt[g] = w_press_b;
        assign btn_level[g]   = r_state[1];
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
        assign btn_hold[g]    = r_hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_nxt;
        end
    end

    assign any_press = r_any_press;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the three raw player buttons (red, blue, yellow) before they reach the menu/state controller and the note-hit judge.
- Per button: 2-flop synchronizer, debounce FSM, clean level, single-cycle press/release pulses, one-shot long-hold pulse.
- Runs on the divided shift clock; outputs replace direct use of raw button pins downstream.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a transition; legal range >= 2.
- HOLD_CYCLES, 64, cycles in HELD before the hold pulse fires; legal range > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  divided system clock (shift clock domain)
- rst  in  1  synchronous, active-high reset
- red_button  in  1  raw asynchronous red button
- blue_button  in  1  raw asynchronous blue button
- yellow_button  in  1  raw asynchronous yellow button
- btn_level  out  3  debounced level {yellow, blue, red}
- btn_press  out  3  1-cycle pulse on accepted press, same bit order
- btn_release  out  3  1-cycle pulse on accepted release
- btn_hold  out  3  1-cycle pulse once per press after HOLD_CYCLES in HELD
- any_press  out  1  OR of btn_press, same cycle

Behaviour:
- Single clock, reset synchronous active-high. While rst=1 at an edge: sync flops, counters and FSMs clear to IDLE. All outputs are 0 after that edge.
- Synchronizer: two flops per button; s = second-stage output. Raw inputs are never used elsewhere.
- Per-button FSM with debounce counter dcnt (width clog2(DEBOUNCE_CYCLES)+1) and hold counter hcnt (width clog2(HOLD_CYCLES)+1):
  - IDLE (level 0): s=1 -> PRESS_WAIT, dcnt=1.
  - PRESS_WAIT: s=0 -> IDLE, dcnt=0, glitch rejected with no pulse. dcnt==DEBOUNCE_CYCLES-1 -> HELD, press pulse, level=1, hcnt=0. Otherwise dcnt++.
  - HELD (level 1): s=0 -> RELEASE_WAIT, dcnt=1. Otherwise hcnt saturates at HOLD_CYCLES. The hold pulse fires on the single cycle hcnt becomes HOLD_CYCLES-1.
  - RELEASE_WAIT (level 1): s=1 -> HELD, hcnt preserved, no pulses. dcnt==DEBOUNCE_CYCLES-1 -> IDLE, release pulse, level=0. Otherwise dcnt++.
- All outputs are registered.
- Latency: raw high first sampled at edge t0 gives btn_press and btn_level high after edge t0+1+DEBOUNCE_CYCLES. The pulse is exactly 1 cycle wide. Release is symmetric.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses on multiple bits.
- Pulses are mutually exclusive per button per cycle. Hold never fires after release has begun. If a release is aborted, hold continues only if it has not already fired.
- At most one hold pulse per press, however long the button is held.
- Reset mid-press: FSM returns to IDLE with no release pulse. A button still held after reset deasserts is treated as a new press, i.e. a press pulse after the full latency.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10):
- Reset, all raw 0 for 20 cycles -> all outputs 0 every cycle.
- red_button high from edge t0, held 30 cycles -> btn_press=3'b001 only in the cycle after edge t0+5. btn_level[0]=1 from then on. btn_hold[0] pulses once. No second hold pulse.
- blue_button 2-cycle glitch, then 0 -> no press, release or level change on bit 1.
- Release red after a 1-cycle low bounce inside RELEASE_WAIT, then stable low -> no release on the bounce. One btn_release[0] pulse 5 edges after stable low starts. Level drops the same cycle.
- red and yellow rise on the same edge -> btn_press=3'b101 in a single cycle and any_press=1 in that cycle.
- rst asserted while yellow is HELD, then deasserted with yellow still high -> outputs 0 during reset. No release pulse. A fresh btn_press[2] follows after the full latency.
